// File: rtl/thread_block_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// thread_block_dispatcher_pkg
// Shared compute-unit definitions used by the thread-block dispatcher:
//   - tbd_state_e      : dispatcher FSM state encoding
//   - lzc_cnt_width()  : count-output width of the lowest-free-id finder
// Block id / index / PC / address widths stay parameters of the modules.
// ---------------------------------------------------------------------------
package thread_block_dispatcher_pkg;

   localparam int unsigned TbdStateBits = 2;

   typedef enum logic [TbdStateBits-1:0] {
      TBD_IDLE     = 2'd0,
      TBD_DISPATCH = 2'd1,
      TBD_DRAIN    = 2'd2,
      TBD_DONE     = 2'd3
   } tbd_state_e;

   // A single-bit vector still needs a one-bit count output.
   function automatic int lzc_cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/thread_block_dispatcher_lzc.sv
// ---------------------------------------------------------------------------
// thread_block_dispatcher_lzc
// Leading/trailing zero counter, port-compatible with the common_cells lzc.
//   in_i    : vector to scan
//   cnt_o   : MODE=0 -> number of trailing zeros (index of lowest set bit)
//             MODE=1 -> number of leading zeros
//   empty_o : no bit of in_i is set (cnt_o is then 0)
// ---------------------------------------------------------------------------
module thread_block_dispatcher_lzc
   import thread_block_dispatcher_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter bit MODE  = 1'b0
) (
   input  logic [WIDTH-1:0]                in_i,
   output logic [lzc_cnt_width(WIDTH)-1:0] cnt_o,
   output logic                            empty_o
);

   localparam int CntWidth = lzc_cnt_width(WIDTH);

   // The scan runs away from the bit that must win, so the last hit
   // assigned is the one closest to the counted end.
   always_comb begin
      cnt_o   = '0;
      empty_o = 1'b1;
      if (MODE == 1'b0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
               cnt_o   = CntWidth'(i);
               empty_o = 1'b0;
            end
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
               cnt_o   = CntWidth'(WIDTH - 1 - i);
               empty_o = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/thread_block_dispatcher.sv
// ---------------------------------------------------------------------------
// thread_block_dispatcher
// Launches a group of N thread blocks onto a compute unit, one warp
// allocation per cycle, tracks in-flight block ids and reports completion
// of the whole group.
//
// Ports
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o  : group-launch handshake
//   cmd_pc_i, cmd_dp_addr_i  : group start PC and data/parameter address
//   cmd_num_tblocks_i        : number of blocks N in the group (0 allowed)
//   warp_free_i              : compute unit can take a warp this cycle
//   allocate_warp_o          : warp allocation fires this cycle
//   allocate_pc_o / allocate_dp_addr_o / allocate_tblock_idx_o /
//   allocate_tblock_id_o     : allocation payload (0 when not allocating)
//   tblock_done_i, tblock_done_id_i : a block finished on the compute unit
//   grp_done_valid_o/grp_done_ready_i : group-completion handshake
//   busy_o                   : a group is in progress
//
// Handshakes: a transfer happens in every cycle where valid and ready are
// both high at the rising edge. A producer holding valid while ready is low
// keeps its payload stable. allocate_warp_o has no ready of its own: it is
// only raised when warp_free_i is already high, so it always transfers.
// ---------------------------------------------------------------------------
module thread_block_dispatcher
   import thread_block_dispatcher_pkg::*;
#(
   parameter int unsigned PcWidth       = 32,
   parameter int unsigned AddressWidth  = 32,
   parameter int unsigned TblockIdxBits = 4,
   parameter int unsigned TblockIdBits  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [PcWidth-1:0]       cmd_pc_i,
   input  logic [AddressWidth-1:0]  cmd_dp_addr_i,
   input  logic [TblockIdxBits:0]   cmd_num_tblocks_i,
   input  logic                     warp_free_i,
   output logic                     allocate_warp_o,
   output logic [PcWidth-1:0]       allocate_pc_o,
   output logic [AddressWidth-1:0]  allocate_dp_addr_o,
   output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
   output logic [TblockIdBits-1:0]  allocate_tblock_id_o,
   input  logic                     tblock_done_i,
   input  logic [TblockIdBits-1:0]  tblock_done_id_i,
   output logic                     grp_done_valid_o,
   input  logic                     grp_done_ready_i,
   output logic                     busy_o
);

   localparam int unsigned NumIds   = 2 ** TblockIdBits;
   // One extra bit so a full group of 2**TblockIdxBits blocks never wraps.
   localparam int unsigned CntWidth = TblockIdxBits + 1;

   tbd_state_e                state_q, state_d;
   logic [PcWidth-1:0]        pc_q, pc_d;
   logic [AddressWidth-1:0]   dp_q, dp_d;
   logic [CntWidth-1:0]       num_q, num_d;
   logic [CntWidth-1:0]       disp_q, disp_d;
   logic [CntWidth-1:0]       comp_q, comp_d;
   logic [NumIds-1:0]         inflight_q, inflight_d;

   logic [NumIds-1:0]         free_vec;
   logic [TblockIdBits-1:0]   free_id;
   logic                      none_free;
   logic                      alloc_fire;
   logic                      done_fire;
   logic [CntWidth-1:0]       comp_total;

   // Lowest free id = lowest set bit of the inverted in-flight bitmap.
   assign free_vec = ~inflight_q;

   thread_block_dispatcher_lzc #(
      .WIDTH (NumIds),
      .MODE  (1'b0)
   ) u_free_lzc (
      .in_i    (free_vec),
      .cnt_o   (free_id),
      .empty_o (none_free)
   );

   assign alloc_fire = (state_q == TBD_DISPATCH) && warp_free_i && !none_free;
   // Completions for ids that are not in flight (or while idle) are dropped.
   assign done_fire  = tblock_done_i && (state_q != TBD_IDLE) &&
                       inflight_q[tblock_done_id_i];
   // Completed count including this cycle's completion, so DRAIN can leave
   // in the same cycle the last block reports back.
   assign comp_total = comp_q + CntWidth'(done_fire);

   assign cmd_ready_o           = (state_q == TBD_IDLE);
   assign busy_o                = (state_q != TBD_IDLE);
   assign grp_done_valid_o      = (state_q == TBD_DONE);
   assign allocate_warp_o       = alloc_fire;
   assign allocate_pc_o         = alloc_fire ? pc_q : '0;
   assign allocate_dp_addr_o    = alloc_fire ? dp_q : '0;
   assign allocate_tblock_idx_o = alloc_fire ? disp_q[TblockIdxBits-1:0] : '0;
   assign allocate_tblock_id_o  = alloc_fire ? free_id : '0;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      dp_d       = dp_q;
      num_d      = num_q;
      disp_d     = disp_q;
      comp_d     = comp_q;
      inflight_d = inflight_q;

      // Allocation and completion touch different ids (free vs in flight),
      // so applying both in one cycle cannot collide.
      if (alloc_fire) begin
         inflight_d[free_id] = 1'b1;
         disp_d              = disp_q + CntWidth'(1);
      end
      if (done_fire) begin
         inflight_d[tblock_done_id_i] = 1'b0;
         comp_d                       = comp_total;
      end

      case (state_q)
         TBD_IDLE: begin
            if (cmd_valid_i) begin
               pc_d       = cmd_pc_i;
               dp_d       = cmd_dp_addr_i;
               num_d      = cmd_num_tblocks_i;
               disp_d     = '0;
               comp_d     = '0;
               inflight_d = '0;
               state_d    = (cmd_num_tblocks_i == '0) ? TBD_DONE : TBD_DISPATCH;
            end
         end
         TBD_DISPATCH: begin
            if (alloc_fire && (disp_d == num_q)) begin
               state_d = TBD_DRAIN;
            end
         end
         TBD_DRAIN: begin
            if (comp_total == num_q) begin
               state_d = TBD_DONE;
            end
         end
         TBD_DONE: begin
            if (grp_done_ready_i) begin
               state_d = TBD_IDLE;
            end
         end
         default: state_d = TBD_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= TBD_IDLE;
         pc_q       <= '0;
         dp_q       <= '0;
         num_q      <= '0;
         disp_q     <= '0;
         comp_q     <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dp_q       <= dp_d;
         num_q      <= num_d;
         disp_q     <= disp_d;
         comp_q     <= comp_d;
         inflight_q <= inflight_d;
      end
   end

   // A completion for an id that is not in flight is tolerated by the logic
   // above but reported, since it points at a compute-unit bug.
   a_done_in_flight : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (tblock_done_i && (state_q != TBD_IDLE)) |-> inflight_q[tblock_done_id_i])
      else $warning("tblock_done_id %0d is not in flight, completion ignored",
                    tblock_done_id_i);

   a_alloc_needs_warp : assert property (@(posedge clk_i) disable iff (!rst_ni)
      allocate_warp_o |-> warp_free_i);

   a_cmd_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cmd_valid_i && !cmd_ready_o) |=>
         ((cmd_pc_i == $past(cmd_pc_i)) &&
          (cmd_dp_addr_i == $past(cmd_dp_addr_i)) &&
          (cmd_num_tblocks_i == $past(cmd_num_tblocks_i))));

endmodule

// File: tb/tb_thread_block_dispatcher.sv
module tb_thread_block_dispatcher;

   localparam logic [31:0] PC = 32'h1000_0040;
   localparam logic [31:0] DP = 32'h2000_0080;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT A: default parameters ----------------
   logic        a_rst_n, a_cmd_valid, a_cmd_ready, a_warp_free, a_alloc;
   logic [4:0]  a_num;
   logic [31:0] a_pc, a_dp;
   logic [3:0]  a_idx, a_id, a_done_id;
   logic        a_done, a_grp_valid, a_grp_ready, a_busy;

   thread_block_dispatcher dut_a (
      .clk_i                 (clk),
      .rst_ni                (a_rst_n),
      .cmd_valid_i           (a_cmd_valid),
      .cmd_ready_o           (a_cmd_ready),
      .cmd_pc_i              (PC),
      .cmd_dp_addr_i         (DP),
      .cmd_num_tblocks_i     (a_num),
      .warp_free_i           (a_warp_free),
      .allocate_warp_o       (a_alloc),
      .allocate_pc_o         (a_pc),
      .allocate_dp_addr_o    (a_dp),
      .allocate_tblock_idx_o (a_idx),
      .allocate_tblock_id_o  (a_id),
      .tblock_done_i         (a_done),
      .tblock_done_id_i      (a_done_id),
      .grp_done_valid_o      (a_grp_valid),
      .grp_done_ready_i      (a_grp_ready),
      .busy_o                (a_busy)
   );

   // ---------------- DUT B: 4 block ids, 8 blocks per group ----------------
   logic        b_rst_n, b_cmd_valid, b_cmd_ready, b_warp_free, b_alloc;
   logic [3:0]  b_num;
   logic [31:0] b_pc, b_dp;
   logic [2:0]  b_idx;
   logic [1:0]  b_id, b_done_id;
   logic        b_done, b_grp_valid, b_grp_ready, b_busy;

   thread_block_dispatcher #(
      .TblockIdxBits (3),
      .TblockIdBits  (2)
   ) dut_b (
      .clk_i                 (clk),
      .rst_ni                (b_rst_n),
      .cmd_valid_i           (b_cmd_valid),
      .cmd_ready_o           (b_cmd_ready),
      .cmd_pc_i              (PC),
      .cmd_dp_addr_i         (DP),
      .cmd_num_tblocks_i     (b_num),
      .warp_free_i           (b_warp_free),
      .allocate_warp_o       (b_alloc),
      .allocate_pc_o         (b_pc),
      .allocate_dp_addr_o    (b_dp),
      .allocate_tblock_idx_o (b_idx),
      .allocate_tblock_id_o  (b_id),
      .tblock_done_i         (b_done),
      .tblock_done_id_i      (b_done_id),
      .grp_done_valid_o      (b_grp_valid),
      .grp_done_ready_i      (b_grp_ready),
      .busy_o                (b_busy)
   );

   // ---------------- vector record ----------------
   typedef struct {
      logic       rst_n;
      logic       cmd_valid;
      logic [4:0] num;
      logic       warp_free;
      logic       done;
      logic [3:0] done_id;
      logic       grp_ready;
      logic       e_ready;
      logic       e_alloc;
      logic [3:0] e_idx;
      logic [3:0] e_id;
      logic       e_grp;
      logic       e_busy;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Inputs: rst_n, cmd_valid, num, warp_free, done, done_id, grp_ready
   // Expected: cmd_ready, alloc, idx, id, grp_done_valid, busy
   function automatic vec_t mk(input int r, cv, num, wf, dn, did, gr,
                               input int er, ea, ei, eid, eg, eb);
      vec_t v;
      v.rst_n     = r[0];
      v.cmd_valid = cv[0];
      v.num       = num[4:0];
      v.warp_free = wf[0];
      v.done      = dn[0];
      v.done_id   = did[3:0];
      v.grp_ready = gr[0];
      v.e_ready   = er[0];
      v.e_alloc   = ea[0];
      v.e_idx     = ei[3:0];
      v.e_id      = eid[3:0];
      v.e_grp     = eg[0];
      v.e_busy    = eb[0];
      return v;
   endfunction

   // ---------------- scoreboard check ----------------
   // Payload outputs are zero whenever no allocation fires.
   task automatic check(input string name, input int k,
                        input logic g_ready, g_alloc,
                        input logic [3:0] g_idx, g_id,
                        input logic g_grp, g_busy,
                        input logic [31:0] g_pc, g_dp,
                        input vec_t v);
      logic [31:0] e_pc;
      logic [31:0] e_dp;
      e_pc = v.e_alloc ? PC : 32'h0;
      e_dp = v.e_alloc ? DP : 32'h0;
      n_vec++;
      if ({g_ready, g_alloc, g_idx, g_id, g_grp, g_busy, g_pc, g_dp} !==
          {v.e_ready, v.e_alloc, v.e_idx, v.e_id, v.e_grp, v.e_busy, e_pc, e_dp}) begin
         n_err++;
         $display("FAIL %s[%0d]: got ready=%b alloc=%b idx=%0d id=%0d grp=%b busy=%b pc=%h dp=%h, want ready=%b alloc=%b idx=%0d id=%0d grp=%b busy=%b pc=%h dp=%h",
                  name, k, g_ready, g_alloc, g_idx, g_id, g_grp, g_busy, g_pc, g_dp,
                  v.e_ready, v.e_alloc, v.e_idx, v.e_id, v.e_grp, v.e_busy, e_pc, e_dp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic apply_a(input vec_t v, input int k);
      @(posedge clk);
      #1;
      a_rst_n     = v.rst_n;
      a_cmd_valid = v.cmd_valid;
      a_num       = v.num;
      a_warp_free = v.warp_free;
      a_done      = v.done;
      a_done_id   = v.done_id;
      a_grp_ready = v.grp_ready;
      @(negedge clk);
      check("tbl", k, a_cmd_ready, a_alloc, a_idx, a_id, a_grp_valid, a_busy,
            a_pc, a_dp, v);
   endtask

   task automatic apply_b(input vec_t v, input int k);
      @(posedge clk);
      #1;
      b_rst_n     = v.rst_n;
      b_cmd_valid = v.cmd_valid;
      b_num       = v.num[3:0];
      b_warp_free = v.warp_free;
      b_done      = v.done;
      b_done_id   = v.done_id[1:0];
      b_grp_ready = v.grp_ready;
      @(negedge clk);
      check("stall", k, b_cmd_ready, b_alloc, {1'b0, b_idx}, {2'b00, b_id},
            b_grp_valid, b_busy, b_pc, b_dp, v);
   endtask

   // ---------------- test ----------------
   initial begin
      int k;
      a_rst_n = 1'b0; a_cmd_valid = 1'b0; a_num = '0; a_warp_free = 1'b0;
      a_done = 1'b0; a_done_id = '0; a_grp_ready = 1'b0;
      b_rst_n = 1'b0; b_cmd_valid = 1'b0; b_num = '0; b_warp_free = 1'b0;
      b_done = 1'b0; b_done_id = '0; b_grp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      b_rst_n = 1'b1;

      // reset state
      vecs.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,0));
      // N=3, warp always free, each block done 5 cycles after allocation
      vecs.push_back(mk(1,1,3,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,1,1,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,2,2,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,1,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,2,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0,1,1));
      vecs.push_back(mk(1,0,0,1,0,0,1, 0,0,0,0,1,1));
      // N=0: straight to DONE, valid held until ready
      vecs.push_back(mk(1,1,0,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0,1,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0,0,1,1));
      vecs.push_back(mk(1,0,0,1,0,0,1, 0,0,0,0,1,1));
      // completion while idle is ignored
      vecs.push_back(mk(1,0,0,1,1,0,0, 1,0,0,0,0,0));
      // N=2 with warp_free 1,0,1
      vecs.push_back(mk(1,1,2,0,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,1,1,0,1));
      vecs.push_back(mk(1,0,0,1,1,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,1,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,1, 0,0,0,0,1,1));
      // N=5: done id1 together with allocation of id3, then spurious id5
      vecs.push_back(mk(1,1,5,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,1,1,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,2,2,0,1));
      vecs.push_back(mk(1,0,0,1,1,1,0, 0,1,3,3,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,4,1,0,1));
      vecs.push_back(mk(1,0,0,1,1,5,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,2,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,3,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,1,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,1, 0,0,0,0,1,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 1,0,0,0,0,0));
      // reset in DRAIN with ids 0,1 in flight, then a fresh group starts at id 0
      vecs.push_back(mk(1,1,2,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,1,1,0,1));
      vecs.push_back(mk(0,0,0,1,0,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,0,0,0, 1,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0,0,0, 0,1,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,0,0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0,0,1, 0,0,0,0,1,1));
      vecs.push_back(mk(1,0,0,1,0,0,0, 1,0,0,0,0,0));

      foreach (vecs[i]) apply_a(vecs[i], i);

      // Id exhaustion on the 4-id instance: N=6, no completions at first.
      k = 0;
      apply_b(mk(1,1,6,1,0,0,0, 1,0,0,0,0,0), k++);
      for (int j = 0; j < 4; j++) apply_b(mk(1,0,0,1,0,0,0, 0,1,j,j,0,1), k++);
      apply_b(mk(1,0,0,1,0,0,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,0,0,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,1,2,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,0,0,0, 0,1,4,2,0,1), k++);
      apply_b(mk(1,0,0,1,0,0,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,1,0,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,0,0,0, 0,1,5,0,0,1), k++);
      apply_b(mk(1,0,0,1,1,1,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,1,3,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,1,2,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,1,0,0, 0,0,0,0,0,1), k++);
      apply_b(mk(1,0,0,1,0,0,1, 0,0,0,0,1,1), k++);
      apply_b(mk(1,0,0,1,0,0,0, 1,0,0,0,0,0), k++);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/thread_block_dispatcher.md
THREAD_BLOCK_DISPATCHER -- requirements
Module: thread_block_dispatcher

Interface
REQ-001 SHALL have parameter PcWidth, default 32, program counter width.
REQ-002 SHALL have parameter AddressWidth, default 32, data/parameter address width.
REQ-003 SHALL have parameter TblockIdxBits, default 4, block-index width; max blocks per group = 2**TblockIdxBits.
REQ-004 SHALL have parameter TblockIdBits, default 4, block-id width; max in-flight blocks = 2**TblockIdBits.
REQ-005 SHALL have clk_i, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have rst_ni, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have cmd_valid_i, input, 1, group-launch request valid.
REQ-008 SHALL have cmd_ready_o, output, 1, launch request accepted.
REQ-009 SHALL have cmd_pc_i, input, PcWidth, group start PC.
REQ-010 SHALL have cmd_dp_addr_i, input, AddressWidth, group data/parameter address.
REQ-011 SHALL have cmd_num_tblocks_i, input, TblockIdxBits+1, number of blocks in group.
REQ-012 SHALL have warp_free_i, input, 1, compute unit has a free warp.
REQ-013 SHALL have allocate_warp_o, allocate_pc_o, allocate_dp_addr_o, allocate_tblock_idx_o, allocate_tblock_id_o; outputs; 1, PcWidth, AddressWidth, TblockIdxBits, TblockIdBits; warp allocation to compute unit.
REQ-014 SHALL have tblock_done_i, input, 1, and tblock_done_id_i, input, TblockIdBits; block completion from compute unit.
REQ-015 SHALL have grp_done_valid_o, output, 1, and grp_done_ready_i, input, 1; group-completion handshake.
REQ-016 SHALL have busy_o, output, 1, group in progress (state != IDLE).

Function
REQ-017 SHALL implement FSM IDLE, DISPATCH, DRAIN, DONE.
REQ-018 SHALL assert cmd_ready_o only in IDLE; on cmd_valid_i&&cmd_ready_o latch PC, dp address, count; clear counters; go DISPATCH, or DONE when count==0.
REQ-019 SHALL assert allocate_warp_o combinationally iff state==DISPATCH && warp_free_i && at least one block id free; an allocation fires that same cycle, no stall.
REQ-020 SHALL drive allocate_tblock_id_o = lowest free id, allocate_tblock_idx_o = dispatched count (0..N-1), PC/address = latched values.
REQ-021 SHALL on fire set in-flight bit of that id and increment dispatched count, visible next cycle.
REQ-022 SHALL on tblock_done_i clear in-flight bit of tblock_done_id_i and increment completed count, in any non-IDLE state.
REQ-023 SHALL apply simultaneous allocation and completion in the same cycle independently.
REQ-024 SHALL ignore tblock_done_i for an id not in flight or in IDLE (no count change).
REQ-025 SHALL go DISPATCH->DRAIN in the cycle the N-th allocation fires.
REQ-026 SHALL go DRAIN->DONE when completed count including the current cycle's completion equals N.
REQ-027 SHALL hold grp_done_valid_o high in DONE until grp_done_ready_i, then go IDLE next cycle.
REQ-028 SHALL stall dispatch with allocate_warp_o=0 while all 2**TblockIdBits ids are in flight; resume the cycle after a completion frees one.
REQ-029 SHALL size counters TblockIdxBits+1 bits so N=2**TblockIdxBits needs no wrap.

Reset
REQ-030 SHALL on rst_ni low at a rising edge enter IDLE, clear in-flight bitmap, counters, latched command, abandoning any group mid-operation.
REQ-031 SHALL output after reset: cmd_ready_o=1, allocate_warp_o=0, grp_done_valid_o=0, busy_o=0, allocate_* data=0.

Structure
REQ-032 SHALL place the FSM state enum in the shared compute-unit package; id/idx/pc/addr types stay module parameters.
REQ-033 SHALL use one sub-module, common_cells lzc, on the inverted in-flight bitmap to pick the lowest free id.
REQ-034 SHALL include non-synthesis assertions: done id in flight; allocate_warp_o implies warp_free_i; cmd fields stable while cmd_valid_i && !cmd_ready_o.

Verification
REQ-035 SHALL cover: N=3, warp_free_i=1, each block done 5 cycles after allocation -> allocations idx 0,1,2 / ids 0,1,2 in consecutive cycles, one grp_done_valid_o.
REQ-036 SHALL cover: N=0 -> DONE next cycle, zero allocations, grp_done_valid_o held until grp_done_ready_i.
REQ-037 SHALL cover: TblockIdBits=2, N=6, no completions -> 4 allocations then stall; done id 2 -> next allocation uses id 2, idx 4.
REQ-038 SHALL cover: warp_free_i toggling 1,0,1 with N=2 -> allocation only in free cycles, idx 0 then 1.
REQ-039 SHALL cover: done of id 1 in same cycle as allocation of id 3 -> both take effect; spurious done of free id 5 ignored and flagged.
REQ-040 SHALL cover: reset asserted in DRAIN with 2 ids in flight -> next cycle IDLE, cmd_ready_o=1, bitmap 0.
